indikator_wr_arb: RTL and testbench
===================================

Name: indikator_wr_arb

Overview:
- Shares the single write port of the MAX7219 indicator (data, position, wrn) between NUM_REQ independent requesters.
- Arbitrates pending digit writes round-robin and latches the winner's digit and position.
- Drives a timed wrn low pulse with programmable setup, low and hold widths, so the indicator's clock-domain synchronisers sample stable data on the falling edge.
- Holds off all writes until the indicator reports indikator_ready.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SETUP_CYC, 4, cycles data/position stable before wrn falls (>=1).
- LOW_CYC, 4, cycles wrn held low (>=1).
- HOLD_CYC, 4, cycles data/position held after wrn rises (>=1).
- ID_W, log2 of NUM_REQ (min 1), width of grant_id; derived, not overridden.

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- init_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester write request, level; held until ack.
- req_data  in  4*NUM_REQ  digit code per requester; slice i = bits [4i+3:4i]; 4'hf = blank.
- req_pos  in  5*NUM_REQ  digit position per requester; slice i = bits [5i+4:5i].
- indikator_ready  in  1  indicator init done; writes start only when 1.
- ack  out  NUM_REQ  one-cycle pulse to the granted requester when its data is latched.
- ind_data  out  4  to indicator data.
- ind_position  out  5  to indicator position.
- ind_wrn  out  1  to indicator wrn; falling edge commits the write.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  ID_W  index of the current or last granted requester.

Behaviour:
- Reset (init_n=0, async):
  - state=IDLE, ind_wrn=1, ind_data=4'hf, ind_position=0.
  - ack=0, busy=0, grant_id=0, rr pointer=NUM_REQ-1 so requester 0 wins first.
  - Reset mid-transaction aborts immediately; ind_wrn returns to 1 asynchronously.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. A down-counter (width fits max of the three CYC params) times each phase.
- IDLE:
  - When indikator_ready=1 and req!=0, select the first asserted req searching from rr+1 upward modulo NUM_REQ.
  - On that edge:
    - latch req_data/req_pos slices into ind_data/ind_position;
    - set grant_id and rr to the winner;
    - set ack[winner]=1 for exactly the next cycle;
    - load counter with SETUP_CYC-1; go to SETUP.
  - With indikator_ready=0, requests are ignored and stay pending.
- SETUP: ind_wrn=1; after SETUP_CYC cycles go to STROBE with counter=LOW_CYC-1.
- STROBE: ind_wrn=0 (registered); after LOW_CYC cycles go to HOLD with counter=HOLD_CYC-1.
- HOLD: ind_wrn=1, data/position unchanged; after HOLD_CYC cycles go to IDLE.
- Timing:
  - Total occupancy per write = 1+SETUP_CYC+LOW_CYC+HOLD_CYC cycles, including the IDLE grant edge.
  - ind_wrn falls exactly SETUP_CYC cycles after ack rises.
  - Back-to-back writes: re-arbitration on the first IDLE cycle.
- Requester rules:
  - Data is sampled only at grant, so a requester may change req_data/req_pos or drop req from the cycle ack is high.
  - A req still high after the ack cycle is a new request.
  - req sampled while busy is ignored until IDLE.
- indikator_ready falling mid-transaction: the current write completes; no new grant.
- Simultaneous requests: exactly one ack per transaction; an ack is never asserted outside the cycle after IDLE grant.
- ind_data, ind_position and ind_wrn are all registered outputs (no glitches into the other clock domain).

Optional Feature:
- Macro IND_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr pointer is not implemented.
- Undefined (default): round-robin as above; a continuously requesting client cannot starve others. Worst-case wait for any requester is NUM_REQ-1 transactions.

Test Plan:
- Reset with init_n=0 mid-STROBE -> ind_wrn=1, busy=0, ack=0 immediately. After release, a req[0] with data 4'h5, pos 3 yields ack[0] one cycle after the grant edge, then ind_wrn low on cycles 5-8 after the grant edge (defaults).
- indikator_ready=0 with req=4'b0010 held 100 cycles -> no ack, ind_wrn stays 1. Raise ready -> ack[1] on the second edge; ind_data/ind_position equal the slice-1 values.
- req=4'b1111 held continuously, ready=1 (round-robin) -> ack order 0,1,2,3,0; one write every 13 cycles; ind_position sequence matches each requester's pos.
- Same stimulus with IND_ARB_FIXED_PRIO_EN defined -> ack[0] on every transaction; requesters 1-3 never acked.
- Requester 2 changes req_data from 4'h7 to 4'h9 in its ack cycle -> ind_data stays 4'h7 through HOLD; ind_data/ind_position stable from grant until IDLE.
- indikator_ready dropped during SETUP -> the write completes (full LOW_CYC low pulse); a pending req[3] gets no ack until ready returns to 1.

Source files
------------

// File: rtl/indikator_wr_arb.sv
// Write-port arbiter for the MAX7219 indicator: grants one requester per write and strobes wrn with setup/low/hold timing.
// Define IND_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module indikator_wr_arb #(
    parameter int NUM_REQ   = 4,
    parameter int SETUP_CYC = 4,
    parameter int LOW_CYC   = 4,
    parameter int HOLD_CYC  = 4,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk_in,
    input  logic                   init_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   req_data,
    input  logic [5*NUM_REQ-1:0]   req_pos,
    input  logic                   indikator_ready,
    output logic [NUM_REQ-1:0]     ack,
    output logic [3:0]             ind_data,
    output logic [4:0]             ind_position,
    output logic                   ind_wrn,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id
);

    localparam int CNT_MAX = (SETUP_CYC > LOW_CYC) ?
                             ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                             ((LOW_CYC > HOLD_CYC) ? LOW_CYC : HOLD_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             found;
    logic [ID_W-1:0]  win;
    logic [3:0]       data_arr [NUM_REQ];
    logic [4:0]       pos_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign data_arr[g] = req_data[4*g +: 4];
        assign pos_arr[g]  = req_pos[5*g +: 5];
    end

    assign busy = (state != IDLE);

`ifdef IND_ARB_FIXED_PRIO_EN
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[ID_W'(i)]) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] rr;

    // Search starts just past the last winner so a persistent requester cannot starve the rest.
    always_comb begin
        int j;
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(rr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req[ID_W'(j)]) begin
                found = 1'b1;
                win   = ID_W'(j);
            end
        end
    end

    always_ff @(posedge clk_in or negedge init_n) begin
        if (!init_n)
            rr <= ID_W'(NUM_REQ - 1);
        else if (state == IDLE && indikator_ready && found)
            rr <= win;
    end
`endif

    always_ff @(posedge clk_in or negedge init_n) begin
        if (!init_n) begin
            state        <= IDLE;
            cnt          <= '0;
            ack          <= '0;
            ind_data     <= 4'hf;
            ind_position <= '0;
            ind_wrn      <= 1'b1;
            grant_id     <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (indikator_ready && found) begin
                        ind_data     <= data_arr[win];
                        ind_position <= pos_arr[win];
                        grant_id     <= win;
                        ack          <= NUM_REQ'(1) << win;
                        cnt          <= CNT_W'(SETUP_CYC - 1);
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        ind_wrn <= 1'b0;
                        cnt     <= CNT_W'(LOW_CYC - 1);
                        state   <= STROBE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        ind_wrn <= 1'b1;
                        cnt     <= CNT_W'(HOLD_CYC - 1);
                        state   <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_indikator_wr_arb.sv
// Directed bench for indikator_wr_arb at default parameters (4 requesters, 4/4/4 cycle phases).
module tb_indikator_wr_arb;

    logic        clk_in = 1'b0;
    logic        init_n;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [19:0] req_pos;
    logic        indikator_ready;
    logic [3:0]  ack;
    logic [3:0]  ind_data;
    logic [4:0]  ind_position;
    logic        ind_wrn;
    logic        busy;
    logic [1:0]  grant_id;

    int pass_cnt  = 0;
    int total_cnt = 0;

    indikator_wr_arb dut (
        .clk_in          (clk_in),
        .init_n          (init_n),
        .req             (req),
        .req_data        (req_data),
        .req_pos         (req_pos),
        .indikator_ready (indikator_ready),
        .ack             (ack),
        .ind_data        (ind_data),
        .ind_position    (ind_position),
        .ind_wrn         (ind_wrn),
        .busy            (busy),
        .grant_id        (grant_id)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        init_n          = 1'b0;
        req             = '0;
        req_data        = '1;
        req_pos         = '0;
        indikator_ready = 1'b1;
        repeat (2) tick();
        init_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        init_n          = 1'b0;
        req             = '0;
        req_data        = '1;
        req_pos         = '0;
        indikator_ready = 1'b1;
        repeat (2) tick();
        total_cnt++; if (ind_wrn !== 1'b1) $display("FAIL reset_wrn: got %b want 1", ind_wrn); else pass_cnt++;
        total_cnt++; if (ind_data !== 4'hf) $display("FAIL reset_data: got %h want f", ind_data); else pass_cnt++;
        total_cnt++; if (ind_position !== 5'd0) $display("FAIL reset_pos: got %0d want 0", ind_position); else pass_cnt++;
        total_cnt++; if ({ack, busy, grant_id} !== 7'd0) $display("FAIL reset_ctrl: got ack=%b busy=%b gid=%0d want 0", ack, busy, grant_id); else pass_cnt++;
        init_n = 1'b1;
        tick();
        req_data[3:0] = 4'h5;
        req_pos[4:0]  = 5'd3;
        req           = 4'b0001;
        tick();
        req = '0;
        repeat (5) tick();
        total_cnt++; if (ind_wrn !== 1'b0) $display("FAIL midstrobe_wrn: got %b want 0", ind_wrn); else pass_cnt++;
        init_n = 1'b0;
        #1;
        total_cnt++; if ({ind_wrn, busy, ack} !== 6'b100000) $display("FAIL async_abort: got wrn=%b busy=%b ack=%b want 1/0/0", ind_wrn, busy, ack); else pass_cnt++;
        tick();
        init_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_write();
        logic [11:0] wrn_obs;
        logic [3:0]  ack_seen;
        req_data[3:0] = 4'h5;
        req_pos[4:0]  = 5'd3;
        req           = 4'b0001;
        tick();
        total_cnt++; if (ack !== 4'b0001) $display("FAIL basic_ack: got %b want 0001", ack); else pass_cnt++;
        total_cnt++; if ({ind_data, ind_position} !== {4'h5, 5'd3}) $display("FAIL basic_latch: got data=%h pos=%0d want 5/3", ind_data, ind_position); else pass_cnt++;
        total_cnt++; if ({busy, grant_id, ind_wrn} !== 4'b1001) $display("FAIL basic_state: got busy=%b gid=%0d wrn=%b want 1/0/1", busy, grant_id, ind_wrn); else pass_cnt++;
        req      = '0;
        ack_seen = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            wrn_obs[k-1] = ind_wrn;
            ack_seen     = ack_seen | ack;
        end
        total_cnt++; if (wrn_obs !== 12'b1111_1000_0111) $display("FAIL basic_wrn_pulse: got %b want 111110000111", wrn_obs); else pass_cnt++;
        total_cnt++; if (ack_seen !== 4'b0000) $display("FAIL basic_ack_once: got %b want 0000", ack_seen); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL basic_idle: got busy=%b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_ready_gating();
        logic [3:0] ack_seen;
        logic       wrn_all;
        do_reset();
        indikator_ready = 1'b0;
        req_data[7:4]   = 4'ha;
        req_pos[9:5]    = 5'd17;
        req             = 4'b0010;
        ack_seen        = '0;
        wrn_all         = 1'b1;
        repeat (100) begin
            tick();
            ack_seen = ack_seen | ack;
            wrn_all  = wrn_all & ind_wrn;
        end
        total_cnt++; if ({ack_seen, wrn_all, busy} !== 6'b000010) $display("FAIL gate_hold: got ack=%b wrn=%b busy=%b want 0000/1/0", ack_seen, wrn_all, busy); else pass_cnt++;
        indikator_ready = 1'b1;
        tick();
        total_cnt++; if (ack !== 4'b0010) $display("FAIL gate_ack: got %b want 0010", ack); else pass_cnt++;
        total_cnt++; if ({ind_data, ind_position, grant_id} !== {4'ha, 5'd17, 2'd1}) $display("FAIL gate_latch: got data=%h pos=%0d gid=%0d want a/17/1", ind_data, ind_position, grant_id); else pass_cnt++;
        req = '0;
        repeat (12) tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL gate_done: got busy=%b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [3:0] extra;
        int         exp_id;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_data[4*i +: 4] = 4'(i + 1);
            req_pos[5*i +: 5]  = 5'(3*i + 2);
        end
        req   = 4'b1111;
        extra = '0;
        for (int t = 0; t < 5; t++) begin
            if (t > 0) begin
                repeat (12) begin
                    tick();
                    extra = extra | ack;
                end
            end
            tick();
`ifdef IND_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = t % 4;
`endif
            total_cnt++; if (ack !== 4'(1 << exp_id)) $display("FAIL rr_ack[%0d]: got %b want id %0d", t, ack, exp_id); else pass_cnt++;
            total_cnt++; if ({ind_data, ind_position} !== {4'(exp_id + 1), 5'(3*exp_id + 2)}) $display("FAIL rr_latch[%0d]: got data=%h pos=%0d want %0d/%0d", t, ind_data, ind_position, exp_id + 1, 3*exp_id + 2); else pass_cnt++;
        end
        total_cnt++; if (extra !== 4'b0000) $display("FAIL rr_stray_ack: got %b want 0000", extra); else pass_cnt++;
        req = '0;
        repeat (12) tick();
    endtask

    task automatic test_data_hold();
        logic stable;
        do_reset();
        req_data[11:8] = 4'h7;
        req_pos[14:10] = 5'd9;
        req            = 4'b0100;
        tick();
        total_cnt++; if ({ack, ind_data} !== {4'b0100, 4'h7}) $display("FAIL hold_grant: got ack=%b data=%h want 0100/7", ack, ind_data); else pass_cnt++;
        req_data[11:8] = 4'h9;
        req_pos[14:10] = 5'd1;
        req            = '0;
        stable         = 1'b1;
        repeat (12) begin
            tick();
            if (ind_data !== 4'h7 || ind_position !== 5'd9) stable = 1'b0;
        end
        total_cnt++; if (stable !== 1'b1) $display("FAIL hold_stable: got data=%h pos=%0d want 7/9 throughout", ind_data, ind_position); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL hold_idle: got busy=%b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_ready_drop();
        int         low_cnt;
        logic [3:0] ack_seen;
        do_reset();
        req_data[3:0] = 4'h5;
        req_pos[4:0]  = 5'd3;
        req_data[15:12] = 4'hc;
        req_pos[19:15]  = 5'd30;
        req           = 4'b0001;
        tick();
        total_cnt++; if (ack !== 4'b0001) $display("FAIL drop_first_ack: got %b want 0001", ack); else pass_cnt++;
        indikator_ready = 1'b0;
        req             = 4'b1000;
        low_cnt         = 0;
        ack_seen        = '0;
        repeat (12) begin
            tick();
            if (ind_wrn === 1'b0) low_cnt++;
            ack_seen = ack_seen | ack;
        end
        total_cnt++; if (low_cnt !== 4) $display("FAIL drop_low_width: got %0d want 4", low_cnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL drop_complete: got busy=%b want 0", busy); else pass_cnt++;
        repeat (20) begin
            tick();
            ack_seen = ack_seen | ack;
        end
        total_cnt++; if ({ack_seen, busy} !== 5'b00000) $display("FAIL drop_no_grant: got ack=%b busy=%b want 0000/0", ack_seen, busy); else pass_cnt++;
        indikator_ready = 1'b1;
        tick();
        total_cnt++; if ({ack, grant_id, ind_data} !== {4'b1000, 2'd3, 4'hc}) $display("FAIL drop_resume: got ack=%b gid=%0d data=%h want 1000/3/c", ack, grant_id, ind_data); else pass_cnt++;
        req = '0;
        repeat (12) tick();
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_ready_gating();
        test_round_robin();
        test_data_hold();
        test_ready_drop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
